// File: rtl/fsm_counter_dispatcher.sv
// Job dispatcher in front of the FSM counter: buffers count jobs in a FIFO and
// issues them one at a time as a run pulse, waiting for the counter's done between jobs.
module fsm_counter_dispatcher #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [CNT_W-1:0]       s_num_cnt,
    output logic                   o_run,
    output logic [CNT_W-1:0]       o_num_cnt,
    input  logic                   i_idle,
    input  logic                   i_done,
    output logic                   o_busy,
    output logic [$clog2(DEPTH):0] o_q_count,
    output logic                   o_zero_drop,
    output logic [15:0]            o_jobs_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int QW = AW + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [QW-1:0]    count_q, count_d;
    logic             run_q, run_d;
    logic [CNT_W-1:0] num_cnt_q, num_cnt_d;
    logic             zero_drop_q, zero_drop_d;
    logic [15:0]      jobs_done_q, jobs_done_d;

    logic accept, push, issue, job_done;

    // Ready depends only on registered occupancy, never on s_valid.
    assign s_ready  = (count_q != QW'(DEPTH));
    assign accept   = s_valid && s_ready;
    assign push     = accept && (s_num_cnt != '0);
    assign issue    = (state_q == S_IDLE) && (count_q != '0) && i_idle;
    assign job_done = (state_q == S_WAIT) && i_done;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, issue})
            2'b10:   count_d = count_q + QW'(1);
            2'b01:   count_d = count_q - QW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage holds data only; validity is tracked by the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_num_cnt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue)  state_d = S_WAIT;
            S_WAIT:  if (i_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        run_d       = issue;
        num_cnt_d   = issue ? mem_q[rd_ptr_q] : num_cnt_q;
        zero_drop_d = accept && (s_num_cnt == '0);
        jobs_done_d = job_done ? jobs_done_q + 16'd1 : jobs_done_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            run_q       <= 1'b0;
            num_cnt_q   <= '0;
            zero_drop_q <= 1'b0;
            jobs_done_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            run_q       <= run_d;
            num_cnt_q   <= num_cnt_d;
            zero_drop_q <= zero_drop_d;
            jobs_done_q <= jobs_done_d;
        end
    end

    assign o_run       = run_q;
    assign o_num_cnt   = num_cnt_q;
    assign o_busy      = (state_q == S_WAIT);
    assign o_q_count   = count_q;
    assign o_zero_drop = zero_drop_q;
    assign o_jobs_done = jobs_done_q;

endmodule

// File: doc/fsm_counter_dispatcher.md
# fsm_counter_dispatcher

Upstream job dispatcher for the FSM counter. It accepts count jobs over a valid/ready handshake and buffers them in a small FIFO. It issues each job to the counter as a one-cycle run pulse with a stable count, but only when the counter reports idle. It then waits for the counter's done pulse before issuing the next job. It sits directly in front of the FSM counter and drives that counter's run and count inputs.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.
- `CNT_W`, default 7: job count width; matches the counter's count input.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `s_valid` in 1: upstream job valid.
- `s_ready` out 1: dispatcher can accept a job.
- `s_num_cnt` in CNT_W: upstream job count.
- `o_run` out 1: one-cycle run pulse to the counter.
- `o_num_cnt` out CNT_W: count presented to the counter.
- `i_idle` in 1: counter idle status.
- `i_done` in 1: counter done pulse.
- `o_busy` out 1: a job is issued and not yet done.
- `o_q_count` out $clog2(DEPTH)+1: current FIFO occupancy, 0..DEPTH.
- `o_zero_drop` out 1: one-cycle pulse when a zero-count job is discarded.
- `o_jobs_done` out 16: completed-job counter.

## Operation
- **Accept:** a job is accepted on any rising edge where `s_valid` and `s_ready` are both 1.
  - `s_ready` = (`o_q_count` != DEPTH); it is registered-state derived with no combinational path from `s_valid`.
  - Upstream must hold `s_valid` and `s_num_cnt` stable until accepted.
- **Zero jobs:** an accepted job with `s_num_cnt` == 0 is not stored.
  - `o_zero_drop` is 1 for the cycle after the accepting edge.
  - FIFO occupancy is unchanged, and the job never reaches the counter.
- **FIFO:** strict first-in first-out, with a registered storage array.
  - Write and read pointers are log2(DEPTH) bits wide and wrap naturally.
  - The occupancy counter is kept separately.
  - Push and pop on the same edge (occupancy between 1 and DEPTH-1): both happen, occupancy unchanged.
  - Push into a full FIFO cannot occur, because `s_ready` is 0.
  - Pop from an empty FIFO never occurs.
- **FSM states:** S_IDLE, S_WAIT.
  - S_IDLE → S_WAIT on an edge where the FIFO is non-empty and `i_idle` is 1. On that edge:
    - pop the head entry,
    - `o_num_cnt` <= head value,
    - `o_run` <= 1.
  - S_WAIT: `o_run` returns to 0 on the next edge. `i_idle` is ignored.
  - S_WAIT → S_IDLE on an edge where `i_done` is 1. On that edge `o_jobs_done` <= `o_jobs_done` + 1, wrapping 65535 → 0.
  - `i_done` while in S_IDLE is ignored and does not count.
- **Outputs:**
  - `o_busy` = (state == S_WAIT).
  - `o_num_cnt` holds its value from the issue edge until the next issue, so it stays stable for the counter's whole run.
  - `o_run` is never high for more than one consecutive cycle.
- **Reset** (asserted at any time, including mid-job):
  - The FIFO is flushed and the state goes to S_IDLE.
  - All outputs go to 0 except `s_ready`, which goes to 1.
  - The counter itself is reset by its own reset; the dispatcher does not wait for `i_done` after reset.

## Timing
- **Reset values:**
  - `s_ready`=1.
  - `o_run`=0, `o_num_cnt`=0, `o_busy`=0, `o_q_count`=0, `o_zero_drop`=0, `o_jobs_done`=0.
- **Best-case latency:** job accepted at edge k into an empty FIFO, with the FSM in S_IDLE and `i_idle`=1.
  - `o_q_count`=1 after edge k.
  - The issue decision happens at edge k+1, so `o_run`=1 during the cycle after edge k+1 (2 cycles after acceptance).
- **`o_q_count` after a same-edge accept and issue:** during S_WAIT the FIFO accepts in parallel. An accept and an issue on the same edge leave `o_q_count` unchanged.
- **Back-to-back jobs:** the minimum gap from the edge that samples `i_done` to the next `o_run` rising is 1 edge.
  - The next issue happens on the first edge where the FSM is in S_IDLE and `i_idle`=1.
  - If the counter raises `i_idle` one cycle after `i_done`, the next issue is on that edge.
- **Full condition:** `s_ready` drops the cycle after the DEPTH-th stored job. It rises again the cycle after the next pop.
- **Reset is asynchronous:** outputs change without waiting for a clock edge. Release is synchronous to the next rising edge, and the bench applies it away from clock edges.

## Test plan
- **Reset:** assert `reset` mid-cycle → all outputs at reset values immediately; `s_ready`=1.
- **Single job:** one job `s_num_cnt`=100 accepted at edge k, counter model idle, counter model pulses `i_done` 100 cycles after `o_run`.
  - `o_run`=1 for exactly 1 cycle, at k+2, with `o_num_cnt`=100.
  - `o_busy` stays 1 until the edge that samples `i_done`.
  - `o_jobs_done`=1 afterwards.
- **Fill and ordering:** jobs 10, 20, 30, 40, 50 offered back-to-back with the counter model busy (`i_idle`=0).
  - `s_ready`=0 once 4 jobs are stored; job 50 is held off.
  - Issues occur in order 10, 20, 30, 40, 50, each only after the previous `i_done`.
  - `o_jobs_done`=5 at the end.
- **Zero job:** job with `s_num_cnt`=0 → `o_zero_drop` pulses once, `o_q_count` stays 0, no `o_run`. A following job of 5 then issues normally.
- **Reset mid-operation:** `reset` asserted while in S_WAIT with 2 jobs queued.
  - `o_q_count`=0, `o_busy`=0, `o_run`=0.
  - After release, a new job of 7 issues with `o_num_cnt`=7.
  - No stale job is ever issued.
- **Spurious done:** `i_done` pulsed in S_IDLE with an empty FIFO → `o_jobs_done` unchanged, no state change.
- **Simultaneous push and pop:** a push on the same edge as an issue, with `o_q_count`=2 → `o_q_count` stays 2.
